uart_rx_frontend: RTL and testbench

Serial receive stage that sits directly upstream of the `task1` byte-processing logic. It synchronizes the raw `rx` pin and recovers 8N1 UART frames, sampled LSB first. Each received byte is presented on a valid/ready holding register for the consumer, and framing and overrun errors are flagged. It runs in the single `clk` domain, 50 MHz nominal (20 ns period).

---
 rtl/uart_rx_frontend.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 2-flop synchronizer, 3-sample majority vote, 8N1 deframer, valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a live parity_err output.
`timescale 1ns/1ps

module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam int                H         = CLKS_PER_BIT / 2;
    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(H - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [1:0]       hist_q;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             maj, fall, line_high, bit_tick, par_ok;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            hist_q    <= 2'b00;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            hist_q    <= {hist_q[0], rx_s_q};
        end
    end

    // History resets low so the forced-high sync flops cannot fake an idle line after reset.
    assign maj       = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
    assign line_high = rx_s_q & hist_q[0] & hist_q[1];
    assign fall      = armed_q & hist_q[0] & ~rx_s_q;
    assign bit_tick  = (cnt_q == CNT_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_err_q, parity_err_d;

    assign par_ok     = (par_q == ^shift_q);
    assign parity_err = parity_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    // NOTE: every signal written below gets a default first, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | line_high;
        cnt_d       = bit_tick ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q & ~ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_START) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = maj ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    shift_d[idx_q] = maj;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    par_d   = maj;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop so the next start edge is never missed.
                if (bit_tick) begin
                    state_d     = S_IDLE;
                    frame_err_d = ~maj;
                    if (!maj) armed_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = ~par_ok;
`endif
                    if (maj && par_ok) begin
                        if (!valid_q || ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at CLKS_PER_BIT=16; honours UART_RX_PARITY_EN for 8E1 frames.
`timescale 1ns/1ps

module tb_uart_rx_frontend;

    localparam int N = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 155 + N;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, overrun, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_rx_frontend #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: pulse counts and the cycle at which each event was seen.
    int         valid_hi = 0, valid_rises = 0, valid_rise_cyc = -1;
    logic [7:0] valid_rise_data = 8'h00;
    int         fe_hi = 0, fe_cyc = -1, pe_hi = 0, ov_hi = 0, ov_cyc = -1;
    int         busy_rises = 0, busy_rise_cyc = -1, busy_fall_cyc = -1;
    logic       valid_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        valid_prev <= valid;
        busy_prev  <= busy;
        if (valid) valid_hi <= valid_hi + 1;
        if (valid && !valid_prev) begin
            valid_rises     <= valid_rises + 1;
            valid_rise_cyc  <= cyc;
            valid_rise_data <= data;
        end
        if (frame_err) begin
            fe_hi  <= fe_hi + 1;
            fe_cyc <= cyc;
        end
        if (parity_err) pe_hi <= pe_hi + 1;
        if (overrun) begin
            ov_hi  <= ov_hi + 1;
            ov_cyc <= cyc;
        end
        if (busy && !busy_prev) begin
            busy_rises    <= busy_rises + 1;
            busy_rise_cyc <= cyc;
        end
        if (!busy && busy_prev) busy_fall_cyc <= cyc;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame LSB first; c_start is the cycle in which the start bit first appears on the pin.
    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip,
                              output int c_start);
        @(posedge clk);
        #1;
        c_start = cyc;
        rx = 1'b0;
        wait_cycles(N);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(N);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        wait_cycles(N);
`else
        if (par_flip) rx = 1'b1;
`endif
        rx = stop_b;
        wait_cycles(N);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        wait_cycles(3);
        checks++; if (data !== 8'h00)    begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        wait_cycles(10);
    endtask

    task automatic test_frame_55;
        int c, vh0, vr0, fe0;
        ready = 1'b1;
        vh0 = valid_hi; vr0 = valid_rises; fe0 = fe_hi;
        send_frame(8'h55, 1'b1, 1'b0, c);
        wait_cycles(5);
        checks++; if (valid_rise_data !== 8'h55) begin errors++; $display("FAIL f55_data got %h want 55", valid_rise_data); end
        checks++; if (valid_rises - vr0 != 1) begin errors++; $display("FAIL f55_valid_count got %0d want 1", valid_rises - vr0); end
        checks++; if (valid_hi - vh0 != 1) begin errors++; $display("FAIL f55_valid_width got %0d want 1", valid_hi - vh0); end
        checks++; if (valid_rise_cyc != c + LAT) begin errors++; $display("FAIL f55_valid_time got %0d want %0d", valid_rise_cyc, c + LAT); end
        checks++; if (busy_rise_cyc != c + 3) begin errors++; $display("FAIL f55_busy_rise got %0d want %0d", busy_rise_cyc, c + 3); end
        checks++; if (busy_fall_cyc != c + LAT) begin errors++; $display("FAIL f55_busy_fall got %0d want %0d", busy_fall_cyc, c + LAT); end
        checks++; if (fe_hi != fe0) begin errors++; $display("FAIL f55_frame_err got %0d want 0", fe_hi - fe0); end
        wait_cycles(10);
    endtask

    task automatic test_glitch;
        int c, vr0, fe0, br0;
        vr0 = valid_rises; fe0 = fe_hi; br0 = busy_rises;
        @(posedge clk);
        #1;
        c  = cyc;
        rx = 1'b0;
        wait_cycles(1);
        rx = 1'b1;
        wait_cycles(30);
        checks++; if (busy_rises - br0 != 1) begin errors++; $display("FAIL glitch_busy_rises got %0d want 1", busy_rises - br0); end
        checks++; if (busy_rise_cyc != c + 3) begin errors++; $display("FAIL glitch_busy_rise got %0d want %0d", busy_rise_cyc, c + 3); end
        checks++; if (busy_fall_cyc != c + 11) begin errors++; $display("FAIL glitch_busy_fall got %0d want %0d", busy_fall_cyc, c + 11); end
        checks++; if (valid_rises != vr0) begin errors++; $display("FAIL glitch_valid got %0d want 0", valid_rises - vr0); end
        checks++; if (fe_hi != fe0) begin errors++; $display("FAIL glitch_frame_err got %0d want 0", fe_hi - fe0); end
    endtask

    task automatic test_frame_err;
        int c, vr0, fe0;
        vr0 = valid_rises; fe0 = fe_hi;
        send_frame(8'hA3, 1'b0, 1'b0, c);
        wait_cycles(20);
        checks++; if (fe_hi - fe0 != 1) begin errors++; $display("FAIL ferr_pulse_width got %0d want 1", fe_hi - fe0); end
        checks++; if (fe_cyc != c + LAT) begin errors++; $display("FAIL ferr_time got %0d want %0d", fe_cyc, c + LAT); end
        checks++; if (valid_rises != vr0) begin errors++; $display("FAIL ferr_valid got %0d want 0", valid_rises - vr0); end
        send_frame(8'h3C, 1'b1, 1'b0, c);
        wait_cycles(5);
        checks++; if (valid_rises - vr0 != 1) begin errors++; $display("FAIL ferr_next_count got %0d want 1", valid_rises - vr0); end
        checks++; if (valid_rise_data !== 8'h3C) begin errors++; $display("FAIL ferr_next_data got %h want 3c", valid_rise_data); end
        checks++; if (fe_hi - fe0 != 1) begin errors++; $display("FAIL ferr_next_frame_err got %0d want 1", fe_hi - fe0); end
        wait_cycles(10);
    endtask

    task automatic test_overrun;
        int c1, c2, ov0;
        ov0   = ov_hi;
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, c1);
        send_frame(8'h22, 1'b1, 1'b0, c2);
        wait_cycles(3);
        checks++; if (valid_rise_cyc != c1 + LAT) begin errors++; $display("FAIL ovr_first_valid got %0d want %0d", valid_rise_cyc, c1 + LAT); end
        checks++; if (data !== 8'h11) begin errors++; $display("FAIL ovr_data_held got %h want 11", data); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held got %b want 1", valid); end
        checks++; if (ov_hi - ov0 != 1) begin errors++; $display("FAIL ovr_pulse_width got %0d want 1", ov_hi - ov0); end
        checks++; if (ov_cyc != c2 + LAT) begin errors++; $display("FAIL ovr_time got %0d want %0d", ov_cyc, c2 + LAT); end
        ready = 1'b1;
        wait_cycles(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_consume_valid got %b want 0", valid); end
        checks++; if (data !== 8'h11) begin errors++; $display("FAIL ovr_consume_data got %h want 11", data); end
        wait_cycles(10);
    endtask

    task automatic test_reset_midframe;
        int c, vr0, fe0, br0;
        ready = 1'b1;
        @(posedge clk);
        #1;
        rx = 1'b0;
        wait_cycles(N);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_cycles(N);
        end
        wait_cycles(5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b want 1", busy); end
        reset = 1'b1;
        rx    = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if ({valid, frame_err, parity_err, overrun} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_flags got %b want 0000", {valid, frame_err, parity_err, overrun});
        end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h want 00", data); end
        wait_cycles(3);
        reset = 1'b0;
        vr0 = valid_rises; fe0 = fe_hi; br0 = busy_rises;
        wait_cycles(20);
        checks++; if (busy_rises != br0) begin errors++; $display("FAIL rst_low_line_busy got %0d want 0", busy_rises - br0); end
        checks++; if (valid_rises != vr0) begin errors++; $display("FAIL rst_low_line_valid got %0d want 0", valid_rises - vr0); end
        rx = 1'b1;
        wait_cycles(20);
        send_frame(8'h81, 1'b1, 1'b0, c);
        wait_cycles(5);
        checks++; if (valid_rises - vr0 != 1) begin errors++; $display("FAIL rst_next_count got %0d want 1", valid_rises - vr0); end
        checks++; if (valid_rise_data !== 8'h81) begin errors++; $display("FAIL rst_next_data got %h want 81", valid_rise_data); end
        checks++; if (fe_hi != fe0) begin errors++; $display("FAIL rst_next_frame_err got %0d want 0", fe_hi - fe0); end
        wait_cycles(10);
    endtask

    task automatic test_parity;
`ifdef UART_RX_PARITY_EN
        int c, vr0, pe0, fe0;
        vr0 = valid_rises; pe0 = pe_hi; fe0 = fe_hi;
        send_frame(8'h07, 1'b1, 1'b1, c);
        wait_cycles(5);
        checks++; if (pe_hi - pe0 != 1) begin errors++; $display("FAIL par_bad_pulse got %0d want 1", pe_hi - pe0); end
        checks++; if (valid_rises != vr0) begin errors++; $display("FAIL par_bad_valid got %0d want 0", valid_rises - vr0); end
        checks++; if (fe_hi != fe0) begin errors++; $display("FAIL par_bad_frame_err got %0d want 0", fe_hi - fe0); end
        send_frame(8'h07, 1'b1, 1'b0, c);
        wait_cycles(5);
        checks++; if (valid_rises - vr0 != 1) begin errors++; $display("FAIL par_good_valid got %0d want 1", valid_rises - vr0); end
        checks++; if (valid_rise_data !== 8'h07) begin errors++; $display("FAIL par_good_data got %h want 07", valid_rise_data); end
        checks++; if (pe_hi - pe0 != 1) begin errors++; $display("FAIL par_good_no_err got %0d want 1", pe_hi - pe0); end
`else
        checks++; if (pe_hi != 0) begin errors++; $display("FAIL no_parity_err_pulses got %0d want 0", pe_hi); end
`endif
    endtask

    initial begin
        test_reset();
        test_frame_55();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
